// File: rtl/lcd_pkg.sv
// Shared state encoding and constants for the LCD I2C backpack writer.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADDR  = 3'd2,
        ACK1  = 3'd3,
        DATA  = 3'd4,
        ACK2  = 3'd5,
        STOP  = 3'd6
    } lcd_state_t;

    localparam logic [6:0] LCD_I2C_ADDR = 7'h27;
    localparam int         BIT_CNT_W    = 3;

endpackage

// File: rtl/lcd_sync_edge.sv
// SDA readback synchroniser and scl_lcd rise/fall detector (scl_lcd is a phase
// reference in the system clock domain, never used as a clock).
module lcd_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic scl_lcd,
    input  logic sda_in,
    output logic sda_sync,
    output logic scl_q,
    output logic rise,
    output logic fall
);

    // Fewer than two flops cannot resolve metastability on the pad input.
    localparam int STG = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STG-1:0] sda_p0;

    always_ff @(posedge clock) begin
        if (reset) begin
            sda_p0 <= '1;
            scl_q  <= 1'b1;
        end else begin
            sda_p0 <= {sda_p0[STG-2:0], sda_in};
            scl_q  <= scl_lcd;
        end
    end

    assign sda_sync = sda_p0[STG-1];
    assign rise     = scl_lcd & ~scl_q;
    assign fall     = ~scl_lcd & scl_q;

endmodule

// File: rtl/lcd_i2c_writer.sv
// Single-byte I2C writer for a PCF8574-style LCD backpack: START, addr+W, ACK,
// data, ACK, STOP. Define LCD_I2C_BURST_EN to chain bytes after ACK2 without STOP.
module lcd_i2c_writer
    import lcd_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = LCD_I2C_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl_lcd,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       scl_out,
    output logic       sda_oe,
    input  logic       sda_in,
    output logic       done,
    output logic       nack
);

    localparam logic [7:0] ADDR_BYTE = {DEV_ADDR, 1'b0};

    lcd_state_t           state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 half;
    logic                 nack_acc;
    logic [7:0]           shift_reg;
    logic [7:0]           tx_sr;

    logic sda_sync, scl_q, rise, fall;
    logic burst_take, load_addr, load_data, shift_en, scl_track;
    logic [7:0] next_byte;

    lcd_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clock    (clock),
        .reset    (reset),
        .scl_lcd  (scl_lcd),
        .sda_in   (sda_in),
        .sda_sync (sda_sync),
        .scl_q    (scl_q),
        .rise     (rise),
        .fall     (fall)
    );

`ifdef LCD_I2C_BURST_EN
    assign burst_take = (state == ACK2) && fall && tx_valid && !nack_acc;
`else
    assign burst_take = 1'b0;
`endif

    assign tx_ready  = (state == IDLE) || burst_take;
    assign load_addr = (state == START) && fall && half;
    assign load_data = ((state == ACK1) && fall && !nack_acc) || burst_take;
    assign shift_en  = ((state == ADDR) || (state == DATA)) && fall && (bit_cnt != '0);
    assign next_byte = burst_take ? tx_data : shift_reg;

    // SCL follows the delayed phase reference while bits move; held high around START/STOP.
    assign scl_track = (state inside {ADDR, DATA, ACK1, ACK2}) || ((state == STOP) && !half);
    assign scl_out   = scl_track ? scl_q : 1'b1;

    always_ff @(posedge clock) begin
        if (tx_valid && tx_ready) shift_reg <= tx_data;
        if (load_addr)      tx_sr <= ADDR_BYTE;
        else if (load_data) tx_sr <= next_byte;
        else if (shift_en)  tx_sr <= {tx_sr[6:0], 1'b0};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            sda_oe   <= 1'b0;
            done     <= 1'b0;
            nack     <= 1'b0;
            bit_cnt  <= '1;
            half     <= 1'b0;
            nack_acc <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        state    <= START;
                        half     <= 1'b0;
                        nack_acc <= 1'b0;
                    end
                end
                START: begin
                    if (rise && !half) begin
                        sda_oe <= 1'b1;
                        half   <= 1'b1;
                    end else if (load_addr) begin
                        state   <= ADDR;
                        sda_oe  <= ~ADDR_BYTE[7];
                        bit_cnt <= '1;
                    end
                end
                ADDR, DATA: begin
                    if (fall) begin
                        if (bit_cnt == '0) begin
                            // Bit 0 has had its full period; release SDA for the slave's ACK.
                            state   <= (state == ADDR) ? ACK1 : ACK2;
                            sda_oe  <= 1'b0;
                            bit_cnt <= '1;
                        end else begin
                            sda_oe  <= ~tx_sr[6];
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                ACK1: begin
                    if (rise) begin
                        nack_acc <= nack_acc | sda_sync;
                    end else if (fall) begin
                        if (nack_acc) begin
                            state  <= STOP;
                            sda_oe <= 1'b1;
                            half   <= 1'b0;
                        end else begin
                            state   <= DATA;
                            sda_oe  <= ~next_byte[7];
                            bit_cnt <= '1;
                        end
                    end
                end
                ACK2: begin
                    if (rise) begin
                        nack_acc <= nack_acc | sda_sync;
                    end else if (burst_take) begin
                        state    <= DATA;
                        sda_oe   <= ~next_byte[7];
                        bit_cnt  <= '1;
                        done     <= 1'b1;
                        nack     <= nack_acc;
                        nack_acc <= 1'b0;
                    end else if (fall) begin
                        state  <= STOP;
                        sda_oe <= 1'b1;
                        half   <= 1'b0;
                    end
                end
                STOP: begin
                    if (rise && !half) begin
                        half <= 1'b1;
                    end else if (fall && half) begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                        done   <= 1'b1;
                        nack   <= nack_acc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_i2c_writer.sv
// Bench for lcd_i2c_writer: divider model, ACKing slave, bus decoder with scoreboard.
`timescale 1ns/1ps
module tb_lcd_i2c_writer;

    localparam logic [31:0] EV_START  = 32'h1000;
    localparam logic [31:0] EV_STOP   = 32'h2000;
    localparam logic [7:0]  ADDR_WR   = 8'h4E;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       scl_lcd  = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_ready, scl_out, sda_oe, sda_in, done, nack;

    logic slave_pull = 1'b0;
    logic mon_hold   = 1'b1;
    logic nack_addr  = 1'b0;
    logic nack_data  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int div      = 0;

    logic [31:0] exp_q[$];
    logic        exp_done_q[$];

    assign sda_in = ~(sda_oe | slave_pull);

    lcd_i2c_writer #(
        .DEV_ADDR    (7'h27),
        .SYNC_STAGES (2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .scl_lcd  (scl_lcd),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .scl_out  (scl_out),
        .sda_oe   (sda_oe),
        .sda_in   (sda_in),
        .done     (done),
        .nack     (nack)
    );

    always #5 clock = ~clock;

    // Divider with threshold 7: scl_lcd toggles every 8 clocks.
    always @(posedge clock) begin
        if (div == 7) begin
            div     <= 0;
            scl_lcd <= ~scl_lcd;
        end else begin
            div <= div + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] byte_ev(input logic [7:0] d, input logic ack);
        return {21'h0, 1'b1, 1'b0, ack, d};
    endfunction

    task automatic push_obs(input logic [31:0] ev);
        if (exp_q.size() == 0) check("bus_unexpected", ev, 32'h0);
        else                   check("bus_event", ev, exp_q.pop_front());
    endtask

    // Bus monitor, protocol checker and slave.
    logic       prev_scl  = 1'b1;
    logic       prev_line = 1'b1;
    logic       prev_done = 1'b0;
    logic       phase_ok  = 1'b0;
    logic       phase_chg = 1'b0;
    logic [8:0] sr        = '0;
    int         bitcnt    = 0;
    int         byte_idx  = 0;
    int         phase_len = 0;

    always @(negedge clock) begin : mon
        logic line;
        line = ~(sda_oe | slave_pull);
        if (mon_hold) begin
            slave_pull = 1'b0;
            bitcnt     = 0;
            byte_idx   = 0;
            phase_ok   = 1'b0;
            phase_chg  = 1'b0;
            prev_scl   = scl_out;
            prev_line  = ~sda_oe;
            prev_done  = done;
        end else begin
            if (done) begin
                check("done_width", 32'(prev_done), 32'd0);
                if (exp_done_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
                else check("done_nack", 32'(nack), 32'(exp_done_q.pop_front()));
            end
            if (line != prev_line) begin
                if (prev_scl && scl_out) begin
                    push_obs(line ? EV_STOP : EV_START);
                    bitcnt   = 0;
                    byte_idx = 0;
                end else if (!prev_scl && scl_out) begin
                    check("sda_at_scl_rise", 32'd1, 32'd0);
                end
                if (scl_out) phase_chg = 1'b1;
            end
            if (scl_out != prev_scl) begin
                if (phase_ok && (!prev_scl || !phase_chg))
                    check(prev_scl ? "scl_high_len" : "scl_low_len", 32'(phase_len), 32'd8);
                phase_ok  = 1'b1;
                phase_chg = 1'b0;
                phase_len = 1;
                if (scl_out) begin
                    sr = {sr[7:0], line};
                    bitcnt++;
                    if (bitcnt == 9) begin
                        push_obs(byte_ev(sr[8:1], sr[0]));
                        bitcnt = 0;
                        byte_idx++;
                    end
                end else begin
                    slave_pull = (bitcnt == 8) && !((byte_idx == 0) ? nack_addr : nack_data);
                end
            end else begin
                phase_len++;
            end
            prev_scl  = scl_out;
            prev_line = line;
            prev_done = done;
        end
    end

    task automatic offer(input logic [7:0] d);
        int w;
        @(negedge clock);
        tx_valid = 1'b1;
        tx_data  = d;
        w = 0;
        while (!tx_ready && w < 2000) begin
            @(negedge clock);
            w++;
        end
        check("accept_seen", 32'(w < 2000), 32'd1);
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic n_addr, input logic n_data,
                        input logic exp_nack, input logic measure, input logic busy_pulse);
        int   cyc;
        logic ready_low_ok;
        nack_addr = n_addr;
        nack_data = n_data;
        exp_q.push_back(EV_START);
        exp_q.push_back(byte_ev(ADDR_WR, n_addr));
        if (!n_addr) exp_q.push_back(byte_ev(d, n_data));
        exp_q.push_back(EV_STOP);
        exp_done_q.push_back(exp_nack);
        offer(d);
        check("ready_busy", 32'(tx_ready), 32'd0);
        cyc = 1;
        ready_low_ok = 1'b1;
        while (!done && cyc < 2000) begin
            if (tx_ready) ready_low_ok = 1'b0;
            if (busy_pulse && cyc == 40) begin
                tx_valid = 1'b1;
                tx_data  = 8'hAA;
            end else if (busy_pulse && cyc == 41) begin
                tx_valid = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("ready_low_while_busy", 32'(ready_low_ok), 32'd1);
        check("ready_after_done", 32'(tx_ready), 32'd1);
        if (measure) check("latency_window", 32'(cyc >= 300 && cyc <= 335), 32'd1);
        repeat (busy_pulse ? 60 : 4) @(negedge clock);
        check("bus_drained", 32'(exp_q.size()), 32'd0);
        check("done_drained", 32'(exp_done_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       n_addr;
        logic       n_data;
        logic       exp_nack;
    } vec_t;

    vec_t vecs[6];

    initial begin : wdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w;
        vecs[0] = '{8'h3C, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 1'b1};

        repeat (3) @(negedge clock);
        check("rst_scl_out", 32'(scl_out), 32'd1);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_nack", 32'(nack), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check("idle_scl_out", 32'(scl_out), 32'd1);
        check("idle_sda_oe", 32'(sda_oe), 32'd0);
        mon_hold = 1'b0;

        for (int i = 0; i < 6; i++)
            send(vecs[i].data, vecs[i].n_addr, vecs[i].n_data, vecs[i].exp_nack, i == 0, 1'b0);

        // Extra request while busy must be ignored.
        send(8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("busy_ignored_idle", 32'(tx_ready), 32'd1);

        // Abort in the middle of the data byte.
        nack_addr = 1'b0;
        nack_data = 1'b0;
        exp_q.push_back(EV_START);
        exp_q.push_back(byte_ev(ADDR_WR, 1'b0));
        exp_q.push_back(byte_ev(8'h5A, 1'b0));
        exp_q.push_back(EV_STOP);
        exp_done_q.push_back(1'b0);
        offer(8'h5A);
        w = 0;
        while (!(byte_idx == 1 && bitcnt == 3 && !scl_out) && w < 2000) begin
            @(negedge clock);
            w++;
        end
        check("reach_data_bit4", 32'(w < 2000), 32'd1);
        repeat (3) @(negedge clock);
        mon_hold = 1'b1;
        reset    = 1'b1;
        @(negedge clock);
        check("abort_scl_out", 32'(scl_out), 32'd1);
        check("abort_sda_oe", 32'(sda_oe), 32'd0);
        check("abort_tx_ready", 32'(tx_ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        exp_done_q.delete();
        repeat (3) @(negedge clock);
        mon_hold = 1'b0;
        send(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back bytes with tx_valid held.
        nack_addr = 1'b0;
        nack_data = 1'b0;
        exp_q.push_back(EV_START);
        exp_q.push_back(byte_ev(ADDR_WR, 1'b0));
        exp_q.push_back(byte_ev(8'h12, 1'b0));
`ifdef LCD_I2C_BURST_EN
        exp_q.push_back(byte_ev(8'h34, 1'b0));
        exp_q.push_back(EV_STOP);
`else
        exp_q.push_back(EV_STOP);
        exp_q.push_back(EV_START);
        exp_q.push_back(byte_ev(ADDR_WR, 1'b0));
        exp_q.push_back(byte_ev(8'h34, 1'b0));
        exp_q.push_back(EV_STOP);
`endif
        exp_done_q.push_back(1'b0);
        exp_done_q.push_back(1'b0);
        @(negedge clock);
        tx_valid = 1'b1;
        tx_data  = 8'h12;
        w = 0;
        while (!tx_ready && w < 2000) begin
            @(negedge clock);
            w++;
        end
        @(negedge clock);
        tx_data = 8'h34;
        w = 0;
        while (!tx_ready && w < 2000) begin
            @(negedge clock);
            w++;
        end
        check("b2b_second_accept", 32'(w < 2000), 32'd1);
        @(negedge clock);
        tx_valid = 1'b0;
        w = 0;
        while (exp_done_q.size() != 0 && w < 3000) begin
            @(negedge clock);
            w++;
        end
        check("b2b_done_count", 32'(exp_done_q.size()), 32'd0);
        repeat (6) @(negedge clock);
        check("b2b_bus_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
